// File: rtl/sfx_pkg.sv
// sfx_pkg: shared state type, default timing constants and priority helpers.
// Build option CRASH_MUTE_EN adds the OVER state after a crash.
package sfx_pkg;

  localparam int unsigned DEF_TICK_DIV    = 100000;
  localparam int unsigned DEF_FLAP_DIV    = 56818;
  localparam int unsigned DEF_SCORE_DIV_A = 63776;
  localparam int unsigned DEF_SCORE_DIV_B = 47778;
  localparam int unsigned DEF_CRASH_DIV   = 254777;
  localparam int unsigned DEF_FLAP_TICKS  = 40;
  localparam int unsigned DEF_SCORE_TICKS = 60;
  localparam int unsigned DEF_CRASH_TICKS = 400;

  typedef enum logic [2:0] {
    IDLE,
    FLAP,
    SCORE_A,
    SCORE_B,
    CRASH
`ifdef CRASH_MUTE_EN
    , OVER
`endif
  } state_t;

  typedef logic [1:0] prio_t;

  localparam prio_t P_NONE  = 2'd0;
  localparam prio_t P_FLAP  = 2'd1;
  localparam prio_t P_SCORE = 2'd2;
  localparam prio_t P_CRASH = 2'd3;

  function automatic prio_t evt_prio(
    input logic f,
    input logic s,
    input logic c
  );
    prio_t p;
    if (c)      p = P_CRASH;
    else if (s) p = P_SCORE;
    else if (f) p = P_FLAP;
    else        p = P_NONE;
    return p;
  endfunction

  function automatic prio_t st_prio(input state_t st);
    prio_t p;
    case (st)
      FLAP:             p = P_FLAP;
      SCORE_A, SCORE_B: p = P_SCORE;
      CRASH:            p = P_CRASH;
      default:          p = P_NONE;
    endcase
    return p;
  endfunction

  function automatic state_t prio_state(input prio_t p);
    state_t st;
    case (p)
      P_CRASH: st = CRASH;
      P_SCORE: st = SCORE_A;
      P_FLAP:  st = FLAP;
      default: st = IDLE;
    endcase
    return st;
  endfunction

  function automatic int unsigned max4(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sfx_mixer_if.sv
// sfx_mixer_if: melody/event inputs and buzzer-side outputs of the mixer.
// master drives the events, slave is the mixer itself.
interface sfx_mixer_if;
  logic music_in;
  logic flap_evt;
  logic score_evt;
  logic crash_evt;
  logic mute;
  logic buzzer;
  logic sfx_active;
  logic music_hold;

  modport master (
    output music_in, flap_evt, score_evt, crash_evt, mute,
    input  buzzer, sfx_active, music_hold
  );

  modport slave (
    input  music_in, flap_evt, score_evt, crash_evt, mute,
    output buzzer, sfx_active, music_hold
  );
endinterface

// File: rtl/sfx_mixer_tone_gen.sv
// tone_gen: square wave with a programmable half-period in clk cycles.
// clear restarts the wave low with the counter at zero.
module tone_gen #(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tone
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;
  logic             wrap;

  // next half-period count and tone level
  always_comb begin
    wrap   = cnt_q >= div - DIV_W'(1);
    cnt_d  = cnt_q + DIV_W'(1);
    tone_d = tone_q;
    if (clear) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
  end

  // counter and tone flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/sfx_mixer.sv
// sfx_mixer: one-shot sound effects pre-empting the melody on the buzzer.
// Define CRASH_MUTE_EN for the OVER state and melody hold after a crash.
module sfx_mixer
  import sfx_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int          DIV_W       = 20,
  parameter int unsigned FLAP_DIV    = DEF_FLAP_DIV,
  parameter int unsigned SCORE_DIV_A = DEF_SCORE_DIV_A,
  parameter int unsigned SCORE_DIV_B = DEF_SCORE_DIV_B,
  parameter int unsigned CRASH_DIV   = DEF_CRASH_DIV,
  parameter int unsigned FLAP_TICKS  = DEF_FLAP_TICKS,
  parameter int unsigned SCORE_TICKS = DEF_SCORE_TICKS,
  parameter int unsigned CRASH_TICKS = DEF_CRASH_TICKS
) (
  input logic        clk,
  input logic        rst,
  sfx_mixer_if.slave bus
);

  localparam int unsigned MAXD =
    max4(FLAP_DIV, SCORE_DIV_A, SCORE_DIV_B, CRASH_DIV);
  localparam int unsigned MAXT =
    max4(FLAP_TICKS, SCORE_TICKS, CRASH_TICKS, 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int TW = $clog2(MAXT + 1);

  if (((MAXD - 1) >> DIV_W) != 0) begin : g_div_w_chk
    $error("DIV_W too narrow for the largest divider");
  end

  state_t           state_q, state_d, nxt;
  prio_t            ep;
  logic [PW-1:0]    pre_q, pre_d;
  logic [TW-1:0]    tcnt_q, tcnt_d, ticks;
  logic [DIV_W-1:0] div;
  logic             tick, done, accept, rest, clr, tone;
  logic             buz_q, buz_d, act_q, hold_q, hold_d;

  // next state: accepted events first, then duration expiry
  always_comb begin
    ep = evt_prio(bus.flap_evt, bus.score_evt, bus.crash_evt);
`ifdef CRASH_MUTE_EN
    if (state_q == OVER) ep = evt_prio(bus.flap_evt, 1'b0, bus.crash_evt);
`endif
    tick  = pre_q == PW'(TICK_DIV - 1);
    ticks = '0;
    div   = DIV_W'(1);
    nxt   = IDLE;
    unique case (state_q)
      FLAP: begin
        ticks = TW'(FLAP_TICKS);
        div   = DIV_W'(FLAP_DIV);
      end
      SCORE_A: begin
        ticks = TW'(SCORE_TICKS);
        div   = DIV_W'(SCORE_DIV_A);
        nxt   = SCORE_B;
      end
      SCORE_B: begin
        ticks = TW'(SCORE_TICKS);
        div   = DIV_W'(SCORE_DIV_B);
      end
      CRASH: begin
        ticks = TW'(CRASH_TICKS);
        div   = DIV_W'(CRASH_DIV);
`ifdef CRASH_MUTE_EN
        nxt   = OVER;
`endif
      end
      default: ;
    endcase
    done    = tick && ticks != '0 && tcnt_q == ticks - TW'(1);
    accept  = ep != P_NONE && ep >= st_prio(state_q);
    state_d = state_q;
    if (done)   state_d = nxt;
    if (accept) state_d = prio_state(ep);
`ifdef CRASH_MUTE_EN
    rest = state_d == IDLE || state_d == OVER;
`else
    rest = state_d == IDLE;
`endif
    clr = accept || done || rest;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // tick prescaler and tick count for the effect duration
  always_comb begin
    pre_d  = pre_q + PW'(1);
    tcnt_d = tcnt_q;
    if (clr) begin
      pre_d  = '0;
      tcnt_d = '0;
    end else if (tick) begin
      pre_d  = '0;
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // duration counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tcnt_q <= '0;
    end else begin
      pre_q  <= pre_d;
      tcnt_q <= tcnt_d;
    end
  end

  tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .div   (div),
    .tone  (tone)
  );

  // output mux: melody when idle, effect tone otherwise, mute wins
  always_comb begin
    buz_d = (state_q == IDLE) ? bus.music_in : tone;
`ifdef CRASH_MUTE_EN
    if (state_q == OVER) buz_d = 1'b0;
    hold_d = state_q == CRASH || state_q == OVER;
`else
    hold_d = 1'b0;
`endif
    if (bus.mute) buz_d = 1'b0;
  end

  // registered pin drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buz_q  <= 1'b0;
      act_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      buz_q  <= buz_d;
      act_q  <= state_q != IDLE;
      hold_q <= hold_d;
    end
  end

  assign bus.buzzer     = buz_q;
  assign bus.sfx_active = act_q;
  assign bus.music_hold = hold_q;

endmodule

// File: tb/tb_sfx_mixer.sv
// tb_sfx_mixer: directed bench for sfx_mixer with shortened timing.
// Covers the OVER/hold path when built with CRASH_MUTE_EN.
module tb_sfx_mixer;

`ifdef CRASH_MUTE_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  sfx_mixer_if bus ();

  sfx_mixer #(
    .TICK_DIV    (10),
    .DIV_W       (20),
    .FLAP_DIV    (3),
    .SCORE_DIV_A (4),
    .SCORE_DIV_B (2),
    .CRASH_DIV   (5),
    .FLAP_TICKS  (4),
    .SCORE_TICKS (3),
    .CRASH_TICKS (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ev: 0 none, 1 flap, 2 score, 3 crash, 7 all three
  task automatic drive_evt(input int ev);
    bus.flap_evt  = (ev == 1 || ev == 7);
    bus.score_evt = (ev == 2 || ev == 7);
    bus.crash_evt = (ev == 3 || ev == 7);
  endtask

  task automatic idle_step(input string tag, input logic m);
    bus.music_in = m;
    step();
    chk({tag, " buz"}, bus.buzzer, m & ~bus.mute);
    chk({tag, " act"}, bus.sfx_active, 0);
    chk({tag, " hold"}, bus.music_hold, 0);
  endtask

  // event sampled on the next edge while the mixer is idle
  task automatic enter(input string tag, input int ev, input logic m);
    drive_evt(ev);
    idle_step({tag, " entry"}, m);
    drive_evt(0);
  endtask

  // len cycles of an effect with half-period div; optional event at pj
  task automatic run_seg(input string tag, input int len, input int div,
                         input int pj, input int pev, input logic hold);
    for (int j = 0; j < len; j++) begin
      if (j == pj) drive_evt(pev);
      step();
      drive_evt(0);
      chk($sformatf("%s buz j%0d", tag, j), bus.buzzer,
          bus.mute ? 0 : (j / div) % 2);
      chk($sformatf("%s act j%0d", tag, j), bus.sfx_active, 1);
      chk($sformatf("%s hold j%0d", tag, j), bus.music_hold, hold);
    end
  endtask

  task automatic crash_tail(input string tag);
`ifdef CRASH_MUTE_EN
    bus.music_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive_evt(2);
      step();
      drive_evt(0);
      chk($sformatf("%s over buz %0d", tag, i), bus.buzzer, 0);
      chk($sformatf("%s over act %0d", tag, i), bus.sfx_active, 1);
      chk($sformatf("%s over hold %0d", tag, i), bus.music_hold, 1);
    end
    drive_evt(1);
    step();
    drive_evt(0);
    chk({tag, " over exit buz"}, bus.buzzer, 0);
    chk({tag, " over exit hold"}, bus.music_hold, 1);
    run_seg({tag, " over flap"}, 40, 3, -1, 0, 1'b0);
    idle_step({tag, " over idle"}, 1'b1);
`else
    idle_step({tag, " end"}, 1'b1);
`endif
  endtask

  initial begin
    logic [15:0] pat;
    bus.music_in = 1'b1;
    bus.mute     = 1'b0;
    drive_evt(0);
    #12;
    chk("rst buz", bus.buzzer, 0);
    chk("rst act", bus.sfx_active, 0);
    chk("rst hold", bus.music_hold, 0);
    step();
    chk("rst hold buz", bus.buzzer, 0);
    rst = 1'b0;

    pat = 16'hB3A5;
    for (int i = 0; i < 16; i++)
      idle_step($sformatf("idle %0d", i), pat[i]);

    enter("flap", 1, 1'b1);
    run_seg("flap", 40, 3, -1, 0, 1'b0);
    idle_step("flap end0", 1'b0);
    idle_step("flap end1", 1'b1);

    enter("retrig", 1, 1'b1);
    run_seg("retrig a", 6, 3, 5, 1, 1'b0);
    run_seg("retrig b", 40, 3, -1, 0, 1'b0);
    idle_step("retrig end", 1'b0);

    enter("score", 2, 1'b1);
    run_seg("score a", 30, 4, -1, 0, 1'b0);
    run_seg("score b", 30, 2, -1, 0, 1'b0);
    idle_step("score end", 1'b1);

    enter("crash", 3, 1'b1);
    run_seg("crash", 60, 5, 5, 1, HOLD);
    crash_tail("crash");

    enter("preempt", 1, 1'b1);
    run_seg("preempt f", 6, 3, 5, 3, 1'b0);
    run_seg("preempt c", 60, 5, -1, 0, HOLD);
    crash_tail("preempt");

    enter("all3", 7, 1'b1);
    run_seg("all3", 60, 5, -1, 0, HOLD);
    crash_tail("all3");

    bus.mute = 1'b1;
    idle_step("mute idle", 1'b1);
    enter("mute", 2, 1'b1);
    run_seg("mute a", 30, 4, -1, 0, 1'b0);
    bus.mute = 1'b0;
    run_seg("mute b", 30, 2, -1, 0, 1'b0);
    idle_step("mute end", 1'b1);

    enter("rstmid", 3, 1'b1);
    run_seg("rstmid", 10, 5, -1, 0, HOLD);
    #2 rst = 1'b1;
    #1;
    chk("rstmid buz", bus.buzzer, 0);
    chk("rstmid act", bus.sfx_active, 0);
    chk("rstmid hold", bus.music_hold, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      idle_step($sformatf("post rst %0d", i), pat[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sfx_mixer.md
Name: sfx_mixer

Overview:
- Output stage directly downstream of the background-melody generator.
- Takes the melody's square wave (music_in) and the game's event pulses: flap, score and crash.
- Plays short one-shot sound effects that pre-empt the melody.
- Drives the physical buzzer pin and the melody generator's hold/restart input.

Parameters:
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz).
- DIV_W, 20: width of the tone half-period counter.
- FLAP_DIV, 56818: flap tone half-period in cycles (880 Hz).
- SCORE_DIV_A, 63776: first score note half-period (784 Hz).
- SCORE_DIV_B, 47778: second score note half-period (1046 Hz).
- CRASH_DIV, 254777: crash tone half-period (196 Hz).
- FLAP_TICKS, 40: flap duration in ticks.
- SCORE_TICKS, 60: duration of each score note in ticks.
- CRASH_TICKS, 400: crash duration in ticks.

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst, in, 1: asynchronous active-high reset.
- music_in, in, 1: melody square wave from the upstream generator.
- flap_evt, in, 1: single-cycle flap pulse.
- score_evt, in, 1: single-cycle score pulse.
- crash_evt, in, 1: single-cycle crash pulse.
- mute, in, 1: level; silences the buzzer pin.
- buzzer, out, 1: registered buzzer pin drive.
- sfx_active, out, 1: high while any effect state is active.
- music_hold, out, 1: high holds the melody generator in reset (its playbar input).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, buzzer=0, sfx_active=0, music_hold=0, tone=0, all counters 0.
- States: IDLE, FLAP, SCORE_A, SCORE_B, CRASH.
- Priority: CRASH > SCORE > FLAP.
- Event handling, sampled each posedge:
  - Highest asserted event wins.
  - It takes effect if its priority is >= the current effect's priority; otherwise it is ignored.
  - Accepted event: target state entered on the next edge. FLAP and SCORE always enter at the start (SCORE always restarts at SCORE_A).
  - On entry: tone=0, half-period counter=0, tick prescaler=0, duration counter=0.
  - A re-trigger of the same effect restarts it from the beginning.
- Tone generation:
  - Half-period counter counts 0..DIV-1.
  - When it reaches DIV-1: tone toggles, counter returns to 0.
  - Result: the first edge appears DIV cycles after entry; period is 2*DIV.
- Duration:
  - Prescaler counts 0..TICK_DIV-1 and issues one tick per wrap.
  - The state ends on the cycle its tick count reaches the parameter value, i.e. after exactly TICKS*TICK_DIV cycles in the state.
  - Exit transitions: FLAP->IDLE, SCORE_A->SCORE_B (counters cleared), SCORE_B->IDLE, CRASH->IDLE.
- Output mux, registered (1-cycle latency):
  - In IDLE, buzzer <= music_in.
  - In any effect state, buzzer <= tone.
  - mute=1 forces buzzer <= 0; the FSM and counters keep running.
- sfx_active is registered: it equals (state != IDLE) one cycle late.
- music_hold is 0 in every state unless CRASH_MUTE_EN is defined.
- Counters never exceed their terminal values. DIV_W must hold the largest DIV parameter minus 1; this is checked by elaboration assertion.
- Reset asserted mid-effect returns immediately to the reset values. No effect resumes after reset.

Optional Feature:
- Macro: CRASH_MUTE_EN.
- Defined:
  - A sixth state, OVER, is entered when CRASH ends.
  - music_hold=1 during CRASH and OVER (registered), which silences and rewinds the melody.
  - In OVER, buzzer=0.
  - OVER exits to FLAP on flap_evt; music_hold drops on that transition.
  - score_evt is ignored in OVER; crash_evt restarts CRASH.
- Undefined: CRASH exits to IDLE and music_hold is constant 0.

Decomposition:
- Package sfx_pkg:
  - state enum, including OVER under the macro;
  - default divider and tick constants;
  - priority encoding function.
- Sub-module tone_gen:
  - Contains the half-period counter and tone flop.
  - Inputs: clk, rst, clear, div.
  - Output: tone.
  - Instantiated once, with div muxed by state.

Test Plan:
All scenarios use TICK_DIV=10, FLAP_DIV=3, SCORE_DIV_A=4, SCORE_DIV_B=2, CRASH_DIV=5, FLAP_TICKS=4, SCORE_TICKS=3, CRASH_TICKS=6.
1. Idle pass-through: music_in toggled randomly, no events -> buzzer equals music_in delayed 1 cycle; sfx_active=0.
2. Flap one-shot: flap_evt pulse -> sfx_active rises 2 cycles later; buzzer toggles every 3 cycles for 40 cycles; then music_in passes through again.
3. Score sequence: score_evt -> 30 cycles at half-period 4, then 30 cycles at half-period 2, then IDLE.
4. Priority/pre-emption: flap_evt 5 cycles into CRASH -> ignored, CRASH lasts the full 60 cycles. crash_evt 5 cycles into FLAP -> CRASH entered and runs 60 cycles. All three events in the same cycle -> CRASH.
5. Mute and reset: mute=1 during SCORE -> buzzer=0, yet SCORE_B starts at cycle 30. rst pulsed mid-CRASH -> all outputs 0 asynchronously; IDLE pass-through after release.
6. CRASH_MUTE_EN build: crash completes -> music_hold stays 1 in OVER and score_evt is ignored. flap_evt -> FLAP plays, music_hold drops, IDLE follows.
